// File: rtl/menu_input_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : menu_input_controller_if
// Description : Key inputs and display/increment outputs of the menu input
//               controller, bundled with master (key source) and slave
//               (controller) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface menu_input_controller_if;
  logic       key_mode;     // raw, active-low
  logic       key_edit;     // raw, active-low
  logic       key_inc;      // raw, active-low
  logic [7:0] selector;
  logic       increment;
  logic       edit_active;

  modport master (
    output key_mode, key_edit, key_inc,
    input  selector, increment, edit_active
  );

  modport slave (
    input  key_mode, key_edit, key_inc,
    output selector, increment, edit_active
  );
endinterface
`default_nettype wire

// File: rtl/menu_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : menu_input_controller
// Description : Synchronizes and debounces three active-low pushbuttons and
//               turns their press events into a display selector code and
//               single-cycle increment pulses (VIEW/EDIT menu FSM).
//               Optional macro MENU_AUTOREPEAT_EN adds auto-repeat on a held
//               increment key while editing.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  menu_input_controller_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // key index 0 = mode, 1 = edit, 2 = inc
  logic [2:0] raw_keys;
  logic [2:0] deb_lvl;   // debounced level, 1 = released
  logic [2:0] deb_dly;   // debounced level one cycle earlier
  logic [2:0] press;     // debounced high-to-low transition

  assign raw_keys = {bus.key_inc, bus.key_edit, bus.key_mode};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_key
      logic          sync1;
      logic          sync2;
      logic          level;
      logic [CW-1:0] cnt;

      // Two-flop synchronizer followed by a consecutive-sample debouncer
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b1;
          sync2 <= 1'b1;
          level <= 1'b1;
          cnt   <= '0;
        end else begin
          sync1 <= raw_keys[i];
          sync2 <= sync1;
          if (sync2 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              level <= sync2;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
      end

      assign deb_lvl[i] = level;
    end
  endgenerate

  // Delay debounced levels by one cycle for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) deb_dly <= 3'b111;
    else        deb_dly <= deb_lvl;
  end

  assign press = deb_dly & ~deb_lvl;

  typedef enum logic [0:0] {VIEW = 1'b0, EDIT = 1'b1} state_t;

  state_t     state, state_nx;
  logic [7:0] sel, sel_nx;
  logic       inc, inc_nx;
  logic       edit_act, edit_act_nx;

`ifdef MENU_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic          rep_on, rep_on_nx;
  logic          rep_first, rep_first_nx;
  logic [RW-1:0] rep_cnt, rep_cnt_nx;

  // Auto-repeat timing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_on    <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      rep_on    <= rep_on_nx;
      rep_first <= rep_first_nx;
      rep_cnt   <= rep_cnt_nx;
    end
  end
`endif

  // Menu state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= VIEW;
      sel      <= 8'd0;
      inc      <= 1'b0;
      edit_act <= 1'b0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      inc      <= inc_nx;
      edit_act <= edit_act_nx;
    end
  end

  // Next-state logic: an edit press always wins and swallows other presses
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    inc_nx   = 1'b0;
`ifdef MENU_AUTOREPEAT_EN
    rep_on_nx    = 1'b0;
    rep_first_nx = rep_first;
    rep_cnt_nx   = rep_cnt;
`endif
    case (state)
      VIEW: begin
        if (press[1]) begin
          if (sel == 8'd4) begin
            state_nx = EDIT;
            sel_nx   = 8'd20;
          end else if (sel == 8'd5) begin
            state_nx = EDIT;
            sel_nx   = 8'd21;
          end
        end else if (press[0]) begin
          sel_nx = {5'd0, sel[2:0] + 3'd1};
        end
      end
      EDIT: begin
        if (press[1]) begin
          state_nx = VIEW;
          sel_nx   = (sel == 8'd20) ? 8'd4 : 8'd5;
        end else if (press[2]) begin
          inc_nx = 1'b1;
`ifdef MENU_AUTOREPEAT_EN
          rep_on_nx    = 1'b1;
          rep_first_nx = 1'b1;
          rep_cnt_nx   = '0;
`endif
        end
`ifdef MENU_AUTOREPEAT_EN
        else if (rep_on && !deb_lvl[2]) begin
          rep_on_nx = 1'b1;
          if ((rep_first  && rep_cnt == RW'(REPEAT_DELAY - 1)) ||
              (!rep_first && rep_cnt == RW'(REPEAT_RATE - 1))) begin
            inc_nx       = 1'b1;
            rep_first_nx = 1'b0;
            rep_cnt_nx   = '0;
          end else begin
            rep_cnt_nx = rep_cnt + RW'(1);
          end
        end
`endif
      end
      default: begin
        state_nx = VIEW;
        sel_nx   = 8'd0;
      end
    endcase
    edit_act_nx = (state_nx == EDIT);
  end

  assign bus.selector    = sel;
  assign bus.increment   = inc;
  assign bus.edit_active = edit_act;

endmodule
`default_nettype wire

// File: tb/tb_menu_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_input_controller
// Description : Scoreboard bench for menu_input_controller. Stimulus tasks
//               push expected selector/increment events computed from the
//               menu rules; a monitor pops and compares on every output event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_input_controller;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int LAT = DEB + 3;

  typedef struct {
    int cyc;
    int sel;
    bit inc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_sel = 0;
  bit   mon_en = 1'b0;
  int   prev_sel = 0;
  ev_t  q[$];

  menu_input_controller_if bus_if ();

  menu_input_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every selector change or increment pulse must match the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: expected sel=%0d inc=%0b at cycle %0d, nothing seen by cycle %0d",
                 q[0].sel, q[0].inc, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (int'(bus_if.selector) != prev_sel || bus_if.increment) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cycle %0d sel=%0d inc=%0b, none required",
                   cyc, bus_if.selector, bus_if.increment);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.sel != int'(bus_if.selector) || e.inc != bus_if.increment) begin
            errors++;
            $display("FAIL event: got cycle %0d sel=%0d inc=%0b, required cycle %0d sel=%0d inc=%0b",
                     cyc, bus_if.selector, bus_if.increment, e.cyc, e.sel, e.inc);
          end
        end
        checks++;
        if (bus_if.edit_active != (bus_if.selector == 8'd20 || bus_if.selector == 8'd21)) begin
          errors++;
          $display("FAIL edit_active: got %0b with sel=%0d", bus_if.edit_active, bus_if.selector);
        end
      end
    end
    prev_sel = int'(bus_if.selector);
  end

  // Menu rules: mask = {inc, edit, mode}, all keys low for 'hold' raw cycles
  task automatic model(input logic [2:0] mask, input int hold, input int t);
    ev_t e;
    int  n;
    if (hold < DEB) return;
    if (mask[1]) begin
      case (m_sel)
        4:  m_sel = 20;
        5:  m_sel = 21;
        20: m_sel = 4;
        21: m_sel = 5;
        default: return;
      endcase
      e = '{t, m_sel, 1'b0};
      q.push_back(e);
    end else if (mask[0] && m_sel < 8) begin
      m_sel = (m_sel + 1) % 8;
      e = '{t, m_sel, 1'b0};
      q.push_back(e);
    end else if (mask[2] && m_sel >= 20) begin
      e = '{t, m_sel, 1'b1};
      q.push_back(e);
`ifdef MENU_AUTOREPEAT_EN
      n = RD;
      while (n < hold) begin
        e = '{t + n, m_sel, 1'b1};
        q.push_back(e);
        n += RR;
      end
`else
      n = 0;
`endif
    end
  endtask

  task automatic set_keys(input logic [2:0] mask);
    bus_if.key_mode = ~mask[0];
    bus_if.key_edit = ~mask[1];
    bus_if.key_inc  = ~mask[2];
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    model(mask, hold, cyc + LAT);
    set_keys(mask);
    repeat (hold) @(negedge clk);
    set_keys(3'b000);
    repeat (14) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bus_if.selector != 8'd0 || bus_if.increment || bus_if.edit_active) begin
      errors++;
      $display("FAIL %s: got sel=%0d inc=%0b edit=%0b, required all 0",
               name, bus_if.selector, bus_if.increment, bus_if.edit_active);
    end
  endtask

  initial begin
    logic [2:0] mask;
    int         hold;
    set_keys(3'b000);
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // eight clean mode presses: 1..7 then wrap to 0
    for (int i = 0; i < 8; i++) press(3'b001, 6);

    // short glitch is rejected, exactly DEB cycles is accepted
    press(3'b001, 3);
    press(3'b001, DEB);

    // to 4, enter edit, three increments, leave edit
    for (int i = 0; i < 3; i++) press(3'b001, 5);
    press(3'b010, 5);
    for (int i = 0; i < 3; i++) press(3'b100, 6);
    press(3'b010, 5);

    // edit ignored at 2; simultaneous mode+edit at 5 enters edit only
    for (int i = 0; i < 6; i++) press(3'b001, 5);
    press(3'b010, 5);
    press(3'b100, 5);
    for (int i = 0; i < 3; i++) press(3'b001, 5);
    press(3'b011, 6);

    // long hold on inc while editing at 21
    press(3'b100, 50);

    // reset during edit with inc held: activity discarded
    @(negedge clk);
    model(3'b100, 60, cyc + LAT);
    set_keys(3'b100);
    repeat (LAT + 10) @(negedge clk);
    mon_en = 1'b0;
    q.delete();
    #2 rst_n = 1'b0;
    #1;
    check_zero("reset_mid_edit");
    m_sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (30) @(negedge clk);
    set_keys(3'b000);
    repeat (14) @(negedge clk);
    check_zero("after_reset_hold");

    // randomized key activity
    for (int i = 0; i < 60; i++) begin
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 2) == 0) mask = 3'b001;
      if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 3);
      else if (mask == 3'b100) hold = $urandom_range(4, 45);
      else hold = $urandom_range(4, 10);
      press(mask, hold);
    end

    repeat (20) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: %0d still queued, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/menu_input_controller.md
MENU_INPUT_CONTROLLER -- requirements
Module: menu_input_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples needed to accept a new key level.
REQ-002 Parameter REPEAT_DELAY, default 25000000: cycles a held KeyInc must stay pressed before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 5000000: cycles between auto-repeat Increment pulses.
REQ-004 Clock  input  1  system clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 KeyMode  input  1  raw pushbutton, active-low, asynchronous to Clock; advances view mode.
REQ-007 KeyEdit  input  1  raw pushbutton, active-low, asynchronous; enters or exits edit mode.
REQ-008 KeyInc  input  1  raw pushbutton, active-low, asynchronous; requests increment.
REQ-009 Selector  output  8  registered display/function code sent to the display multiplexer.
REQ-010 Increment  output  1  registered single-cycle pulse for the add/remove counters.
REQ-011 EditActive  output  1  registered; high while Selector is an edit code (20 or 21).

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 A press event SHALL be the debounced high-to-low transition; release events SHALL have no effect except ending auto-repeat.
REQ-014 Latency from a raw key edge held stable to the resulting Selector/Increment change SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-015 FSM states: VIEW (Selector 0..7) and EDIT (Selector 20 or 21).
REQ-016 In VIEW, a KeyMode press SHALL set Selector to (Selector+1) mod 8; 7 wraps to 0.
REQ-017 In VIEW, a KeyEdit press SHALL go to EDIT with Selector 20 if Selector==4, 21 if Selector==5; otherwise it SHALL be ignored.
REQ-018 In EDIT, a KeyEdit press SHALL return to VIEW restoring Selector 4 (from 20) or 5 (from 21).
REQ-019 In EDIT, KeyMode presses SHALL be ignored.
REQ-020 In EDIT, each KeyInc press SHALL produce exactly one Increment pulse of one cycle; in VIEW, KeyInc SHALL produce no pulse.
REQ-021 Simultaneous press events in one cycle: KeyEdit SHALL take priority; KeyMode and KeyInc events in that cycle are discarded.
REQ-022 No Increment pulse SHALL be issued in the cycle EDIT is exited, nor after exit until a new press in a later EDIT session.
REQ-023 Selector SHALL only ever hold values 0..7, 20, 21.
REQ-024 EditActive SHALL equal (Selector==20 || Selector==21) every cycle.

Reset
REQ-025 On Reset low, SHALL immediately force: Selector=0, Increment=0, EditActive=0, FSM=VIEW, debounced levels=released (high), all counters=0.
REQ-026 Synchronizer flops SHALL reset to released (high), so a key held through reset release generates no press event.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard that activity; no pulse after release.

Configuration
REQ-028 Macro MENU_AUTOREPEAT_EN: when defined, a KeyInc held in EDIT SHALL emit a pulse at press, another REPEAT_DELAY cycles later, then every REPEAT_RATE cycles until release or EDIT exit.
REQ-029 Without MENU_AUTOREPEAT_EN, exactly one Increment pulse per KeyInc press regardless of hold time; repeat counters SHALL not be synthesized.

Verification (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-030 8 clean KeyMode presses from reset -> Selector 1,2,...,7,0; each change 7 cycles after raw edge; Increment stays 0.
REQ-031 KeyMode glitch low for 3 cycles -> no Selector change; low for 4+ cycles -> one advance.
REQ-032 Advance to 4, KeyEdit, 3 KeyInc presses, KeyEdit -> Selector 20, exactly 3 one-cycle Increment pulses, Selector back to 4, EditActive 0->1->0.
REQ-033 Selector=2, KeyEdit press -> Selector stays 2, EditActive 0; then KeyMode and KeyEdit raw edges same cycle at Selector=5 -> Selector 21, no advance.
REQ-034 With MENU_AUTOREPEAT_EN, Selector=21, KeyInc held 50 debounced cycles -> pulses at debounced cycles 0,20,25,30,35,40,45; without macro -> single pulse at 0.
REQ-035 Reset low while in EDIT with KeyInc held -> Selector 0, outputs 0 asynchronously; after release with key still held, no Increment and no Selector change.
